piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, with a framing strobe on the last bit. It is the transmit end of the serial-in shift-register link. It feeds that 4-stage shift-register receiver, or any single-wire bit-serial consumer, and sits between a parallel datapath and that consumer.

---
 rtl/serializer_pkg.sv | 18 +
 rtl/piso_bit_cnt.sv | 35 +++
 rtl/piso_serializer.sv | 126 ++++++++++++
 tb/tb_piso_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the bit-serial link: FSM state encoding and the
// WIDTH-to-counter-width helper.
package serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Bits needed to count down from width-1 to 0.
    function automatic int cnt_width(input int width);
        return (width > 32'sd1) ? $clog2(width) : 32'sd1;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter tracking how many bits of the current word remain
// after the one being presented.
module piso_bit_cnt
    import serializer_pkg::*;
#(
    parameter int CNT_W = cnt_width(8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word input, one bit per
// enabled clock out, with a strobe marking the final bit of each word.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sout_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_r, state_d;
    logic [WIDTH-1:0] sr_r, sr_d;
    logic             sout_r, sout_d;
    logic             sout_valid_r, sout_valid_d;
    logic             sout_last_r, sout_last_d;
    logic [CNT_W-1:0] cnt_s;
    logic             zero_s;
    logic             accept_s;
    logic             shift_s;
    logic             end_s;

    assign din_ready = (state_r == S_IDLE) |
                       ((state_r == S_SHIFT) & sout_last_r & sout_en);
    assign accept_s  = din_valid & din_ready;
    assign shift_s   = (state_r == S_SHIFT) & sout_en & ~zero_s;
    assign end_s     = (state_r == S_SHIFT) & sout_en & sout_last_r;

    piso_bit_cnt #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .en       (shift_s),
        .load_val (CNT_W'(WIDTH - 1)),
        .cnt      (cnt_s),
        .zero     (zero_s)
    );

    // Next-state logic; an accept on the last bit chains straight into the next word.
    always_comb begin
        state_d = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (end_s && !accept_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: the presented bit always mirrors the head of sr.
    always_comb begin
        sr_d         = sr_r;
        sout_d       = sout_r;
        sout_valid_d = sout_valid_r;
        sout_last_d  = sout_last_r;
        if (accept_s) begin
            sr_d         = din;
            sout_d       = (MSB_FIRST != 32'sd0) ? din[WIDTH-1] : din[0];
            sout_valid_d = 1'b1;
            sout_last_d  = 1'b0;
        end else if (shift_s) begin
            if (MSB_FIRST != 32'sd0) begin
                sr_d   = {sr_r[WIDTH-2:0], 1'b0};
                sout_d = sr_r[WIDTH-2];
            end else begin
                sr_d   = {1'b0, sr_r[WIDTH-1:1]};
                sout_d = sr_r[1];
            end
            sout_valid_d = 1'b1;
            sout_last_d  = (cnt_s == CNT_W'(1));
        end else if (end_s) begin
            sout_valid_d = 1'b0;
            sout_last_d  = 1'b0;
        end else begin
            sout_valid_d = sout_valid_r;
            sout_last_d  = sout_last_r;
        end
    end

    // State, shift register and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            sr_r         <= {WIDTH{1'b0}};
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
        end else begin
            state_r      <= state_d;
            sr_r         <= sr_d;
            sout_r       <= sout_d;
            sout_valid_r <= sout_valid_d;
            sout_last_r  <= sout_last_d;
        end
    end

    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;
    assign busy       = (state_r == S_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance, WIDTH=8, expected bit streams written out by hand.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din1, din2;
    logic       din_valid1, din_valid2;
    logic       din_ready1, din_ready2;
    logic       sout_en1, sout_en2;
    logic       sout1, sout2;
    logic       sout_valid1, sout_valid2;
    logic       sout_last1, sout_last2;
    logic       busy1, busy2;

    int n_tests;
    int n_fail;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .sout_en(sout_en1), .sout(sout1),
        .sout_valid(sout_valid1), .sout_last(sout_last1), .busy(busy1)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .sout_en(sout_en2), .sout(sout2),
        .sout_valid(sout_valid2), .sout_last(sout_last2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full MSB-first word; expected bit k is w[7-k].
    task automatic send_msb(input string tag, input logic [7:0] w);
        din1 = w;
        din_valid1 = 1'b1;
        tick();
        din_valid1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_bit"}, 32'(sout1), 32'(w[7-k]));
            chk({tag, "_valid"}, 32'(sout_valid1), 32'd1);
            chk({tag, "_last"}, 32'(sout_last1), 32'(k == 7));
            tick();
        end
        chk({tag, "_end_valid"}, 32'(sout_valid1), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy1), 32'd0);
    endtask

    // One full LSB-first word; expected bit k is w[k].
    task automatic send_lsb(input string tag, input logic [7:0] w);
        din2 = w;
        din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_bit"}, 32'(sout2), 32'(w[k]));
            chk({tag, "_last"}, 32'(sout_last2), 32'(k == 7));
            tick();
        end
        chk({tag, "_end_valid"}, 32'(sout_valid2), 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        din1 = 8'h00; din2 = 8'h00;
        din_valid1 = 1'b0; din_valid2 = 1'b0;
        sout_en1 = 1'b1; sout_en2 = 1'b1;
        tick();
        tick();
        rst = 1'b1;

        chk("rst_sout", 32'(sout1), 32'd0);
        chk("rst_valid", 32'(sout_valid1), 32'd0);
        chk("rst_last", 32'(sout_last1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ready", 32'(din_ready1), 32'd1);

        // Basic MSB-first: A5 -> 1,0,1,0,0,1,0,1
        send_msb("basic", 8'hA5);

        // Back-to-back A5 then 3C with no gap
        din1 = 8'hA5;
        din_valid1 = 1'b1;
        tick();
        din1 = 8'h3C;
        for (int k = 0; k < 16; k++) begin
            w = (k < 8) ? 8'hA5 : 8'h3C;
            chk("b2b_bit", 32'(sout1), 32'(w[7 - (k % 8)]));
            chk("b2b_valid", 32'(sout_valid1), 32'd1);
            chk("b2b_last", 32'(sout_last1), 32'((k % 8) == 7));
            if (k == 3) chk("b2b_ready_mid", 32'(din_ready1), 32'd0);
            if (k == 7) chk("b2b_ready_last", 32'(din_ready1), 32'd1);
            tick();
            if (k == 7) din_valid1 = 1'b0;
        end
        chk("b2b_end_valid", 32'(sout_valid1), 32'd0);
        chk("b2b_end_busy", 32'(busy1), 32'd0);

        // Stall 3 cycles on bit 3 of F0, with a competing offer that must be ignored
        w = 8'hF0;
        din1 = w;
        din_valid1 = 1'b1;
        tick();
        din_valid1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("stall_bit", 32'(sout1), 32'(w[7-k]));
            chk("stall_last", 32'(sout_last1), 32'(k == 7));
            if (k == 3) begin
                din1 = 8'hFF;
                din_valid1 = 1'b1;
                sout_en1 = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_hold_bit", 32'(sout1), 32'd1);
                    chk("stall_hold_last", 32'(sout_last1), 32'd0);
                    chk("stall_hold_valid", 32'(sout_valid1), 32'd1);
                    chk("stall_hold_cnt", 32'(u_msb.cnt_s), 32'd4);
                    chk("stall_ready", 32'(din_ready1), 32'd0);
                end
                sout_en1 = 1'b1;
                din_valid1 = 1'b0;
                din1 = w;
            end
            tick();
        end
        chk("stall_end_valid", 32'(sout_valid1), 32'd0);

        // LSB-first instance
        send_lsb("lsb01", 8'h01);
        send_lsb("lsb2d", 8'h2D);

        // Reset during bit 4 of 5A (that bit is a 1)
        w = 8'h5A;
        din1 = w;
        din_valid1 = 1'b1;
        tick();
        din_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mrst_bit", 32'(sout1), 32'(w[7-k]));
            tick();
        end
        chk("mrst_bit4", 32'(sout1), 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_valid", 32'(sout_valid1), 32'd0);
        chk("mrst_sout", 32'(sout1), 32'd0);
        chk("mrst_last", 32'(sout_last1), 32'd0);
        chk("mrst_busy", 32'(busy1), 32'd0);
        chk("mrst_ready", 32'(din_ready1), 32'd1);
        rst = 1'b1;
        send_msb("after_rst", 8'hC3);

        // Backpressure: changing din while busy; only 96 then 6B go out
        din1 = 8'h96;
        din_valid1 = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            w = (k < 8) ? 8'h96 : 8'h6B;
            chk("bp_bit", 32'(sout1), 32'(w[7 - (k % 8)]));
            chk("bp_last", 32'(sout_last1), 32'((k % 8) == 7));
            chk("bp_busy", 32'(busy1), 32'd1);
            if (k < 7) din1 = 8'h11 * 8'(k + 1);
            if (k == 7) din1 = 8'h6B;
            if (k == 8) din_valid1 = 1'b0;
            tick();
            if (k == 7) din1 = 8'hE7;
        end
        chk("bp_end_valid", 32'(sout_valid1), 32'd0);
        chk("bp_end_busy", 32'(busy1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
